stopwatch_lap_ctrl: RTL and testbench



---
 rtl/stopwatch_lap_ctrl.sv | 149 ++++++++++++++
 tb/tb_stopwatch_lap_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_lap_ctrl.sv
// Two-button MM:SS stopwatch sequencer: one-second timebase, BCD count, lap-freeze display.
// Outputs decode from registers only; pulses sampled at edge N take effect from cycle N+1.
module stopwatch_lap_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_hw_n,
  input  logic        start_stop_pulse,
  input  logic        lap_reset_pulse,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        max_reached
);

  localparam int            PW   = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_LAP,
    S_LOCK
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_presc;
  logic [15:0]   r_cnt;
  logic [15:0]   r_lap;
  logic [15:0]   w_cnt_inc;
  logic          w_counting;
  logic          w_tick;
  logic          w_hit_max;
  logic          w_lap_cap;

  assign w_counting = (r_state == S_RUN) || (r_state == S_LAP);
  assign w_tick     = w_counting && (r_presc == PMAX);
  assign w_hit_max  = w_tick && (w_cnt_inc == 16'h5959);

  // Ripple-carry BCD increment; the top digit never needs to wrap since 59:59 locks.
  always_comb begin
    w_cnt_inc = r_cnt;
    if (r_cnt[3:0] != 4'd9) begin
      w_cnt_inc[3:0] = r_cnt[3:0] + 4'd1;
    end else begin
      w_cnt_inc[3:0] = 4'd0;
      if (r_cnt[7:4] != 4'd5) begin
        w_cnt_inc[7:4] = r_cnt[7:4] + 4'd1;
      end else begin
        w_cnt_inc[7:4] = 4'd0;
        if (r_cnt[11:8] != 4'd9) begin
          w_cnt_inc[11:8] = r_cnt[11:8] + 4'd1;
        end else begin
          w_cnt_inc[11:8] = 4'd0;
          if (r_cnt[15:12] != 4'd5) begin
            w_cnt_inc[15:12] = r_cnt[15:12] + 4'd1;
          end else begin
            w_cnt_inc[15:12] = 4'd0;
          end
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lap_cap   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_stop_pulse) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_hit_max) begin
          w_state_nxt = S_LOCK;
        end else if (start_stop_pulse) begin
          w_state_nxt = S_PAUSE;
        end else if (lap_reset_pulse) begin
          w_state_nxt = S_LAP;
          w_lap_cap   = 1'b1;
        end
      end
      S_LAP: begin
        if (w_hit_max) begin
          w_state_nxt = S_LOCK;
        end else if (start_stop_pulse) begin
          w_state_nxt = S_PAUSE;
        end else if (lap_reset_pulse) begin
          w_state_nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (start_stop_pulse) begin
          w_state_nxt = S_RUN;
        end else if (lap_reset_pulse) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOCK: begin
        if (lap_reset_pulse) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_hw_n) begin
    if (!rst_hw_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Prescaler holds outside RUN/LAP so sub-second phase survives a pause.
  always_ff @(posedge clk or negedge rst_hw_n) begin
    if (!rst_hw_n) begin
      r_presc <= '0;
    end else if (w_state_nxt == S_IDLE) begin
      r_presc <= '0;
    end else if (w_counting) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_hw_n) begin
    if (!rst_hw_n) begin
      r_cnt <= 16'h0000;
    end else if (w_state_nxt == S_IDLE) begin
      r_cnt <= 16'h0000;
    end else if (w_tick) begin
      r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_hw_n) begin
    if (!rst_hw_n) begin
      r_lap <= 16'h0000;
    end else if (w_lap_cap) begin
      r_lap <= r_cnt;
    end
  end

  assign disp_bcd    = (r_state == S_LAP) ? r_lap : r_cnt;
  assign running     = w_counting;
  assign lap_active  = (r_state == S_LAP);
  assign max_reached = (r_state == S_LOCK);

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl: TICK_DIV=4 instance for sequencing, TICK_DIV=2 for lock.
module tb_stopwatch_lap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        ss4, lr4, ss2, lr2;
  logic [15:0] disp4, disp2;
  logic        run4, lap4, max4, run2, lap2, max2;
  int          checks;
  int          errors;

  stopwatch_lap_ctrl #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_hw_n(rst_n), .start_stop_pulse(ss4), .lap_reset_pulse(lr4),
    .disp_bcd(disp4), .running(run4), .lap_active(lap4), .max_reached(max4)
  );

  stopwatch_lap_ctrl #(.TICK_DIV(2)) dut2 (
    .clk(clk), .rst_hw_n(rst_n), .start_stop_pulse(ss2), .lap_reset_pulse(lr2),
    .disp_bcd(disp2), .running(run2), .lap_active(lap2), .max_reached(max2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse4(input logic ss, input logic lr);
    ss4 = ss;
    lr4 = lr;
    step(1);
    ss4 = 1'b0;
    lr4 = 1'b0;
  endtask

  task automatic pulse2(input logic ss, input logic lr);
    ss2 = ss;
    lr2 = lr;
    step(1);
    ss2 = 1'b0;
    lr2 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (disp4 !== 16'h0000) begin errors++; $display("FAIL reset_disp4 got %h want 0000", disp4); end
    checks++; if ({run4, lap4, max4} !== 3'b000) begin errors++; $display("FAIL reset_flags4 got %b want 000", {run4, lap4, max4}); end
    checks++; if ({disp2, run2, lap2, max2} !== 19'h0) begin errors++; $display("FAIL reset_dut2 got %h want 0", {disp2, run2, lap2, max2}); end
    step(1);
    rst_n = 1'b1;
    step(1);
    pulse4(1'b0, 1'b1);
    checks++; if ({disp4, run4} !== 17'h0) begin errors++; $display("FAIL idle_lap_reset got %h want 0", {disp4, run4}); end
  endtask

  task automatic test_run();
    do_reset();
    pulse4(1'b1, 1'b0);
    checks++; if (run4 !== 1'b1) begin errors++; $display("FAIL run_start got %b want 1", run4); end
    step(3);
    checks++; if (disp4 !== 16'h0000) begin errors++; $display("FAIL run_3cyc got %h want 0000", disp4); end
    step(1);
    checks++; if (disp4 !== 16'h0001) begin errors++; $display("FAIL run_4cyc got %h want 0001", disp4); end
    step(36);
    checks++; if (disp4 !== 16'h0010) begin errors++; $display("FAIL run_40cyc got %h want 0010", disp4); end
  endtask

  task automatic test_lap();
    do_reset();
    pulse4(1'b1, 1'b0);
    step(20);
    checks++; if (disp4 !== 16'h0005) begin errors++; $display("FAIL lap_pre got %h want 0005", disp4); end
    pulse4(1'b0, 1'b1);
    checks++; if ({lap4, run4, disp4} !== {2'b11, 16'h0005}) begin errors++; $display("FAIL lap_enter got %h want 30005", {lap4, run4, disp4}); end
    step(12);
    checks++; if ({lap4, disp4} !== {1'b1, 16'h0005}) begin errors++; $display("FAIL lap_frozen got %h want 10005", {lap4, disp4}); end
    pulse4(1'b0, 1'b1);
    checks++; if ({lap4, run4, disp4} !== {2'b01, 16'h0008}) begin errors++; $display("FAIL lap_exit got %h want 10008", {lap4, run4, disp4}); end
  endtask

  task automatic test_pause();
    do_reset();
    pulse4(1'b1, 1'b0);
    step(5);
    pulse4(1'b1, 1'b0);
    checks++; if ({run4, disp4} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL pause_enter got %h want 00001", {run4, disp4}); end
    step(100);
    checks++; if (disp4 !== 16'h0001) begin errors++; $display("FAIL pause_hold got %h want 0001", disp4); end
    pulse4(1'b1, 1'b0);
    checks++; if (run4 !== 1'b1) begin errors++; $display("FAIL resume_run got %b want 1", run4); end
    step(1);
    checks++; if (disp4 !== 16'h0001) begin errors++; $display("FAIL resume_1cyc got %h want 0001", disp4); end
    step(1);
    checks++; if (disp4 !== 16'h0002) begin errors++; $display("FAIL resume_2cyc got %h want 0002", disp4); end
    pulse4(1'b1, 1'b0);
    pulse4(1'b0, 1'b1);
    checks++; if ({run4, disp4} !== 17'h0) begin errors++; $display("FAIL pause_clear got %h want 0", {run4, disp4}); end
    pulse4(1'b1, 1'b0);
    step(3);
    checks++; if (disp4 !== 16'h0000) begin errors++; $display("FAIL clr_presc_3cyc got %h want 0000", disp4); end
    step(1);
    checks++; if (disp4 !== 16'h0001) begin errors++; $display("FAIL clr_presc_4cyc got %h want 0001", disp4); end
  endtask

  task automatic test_tick_on_pause();
    do_reset();
    pulse4(1'b1, 1'b0);
    step(3);
    pulse4(1'b1, 1'b0);
    checks++; if ({run4, disp4} !== {1'b0, 16'h0001}) begin errors++; $display("FAIL tick_at_pause got %h want 00001", {run4, disp4}); end
    step(10);
    checks++; if (disp4 !== 16'h0001) begin errors++; $display("FAIL tick_at_pause_hold got %h want 0001", disp4); end
  endtask

  task automatic test_wrap();
    do_reset();
    pulse4(1'b1, 1'b0);
    step(236);
    checks++; if (disp4 !== 16'h0059) begin errors++; $display("FAIL wrap_0059 got %h want 0059", disp4); end
    step(4);
    checks++; if (disp4 !== 16'h0100) begin errors++; $display("FAIL wrap_0100 got %h want 0100", disp4); end
    step(2156);
    checks++; if (disp4 !== 16'h0959) begin errors++; $display("FAIL wrap_0959 got %h want 0959", disp4); end
    step(4);
    checks++; if (disp4 !== 16'h1000) begin errors++; $display("FAIL wrap_1000 got %h want 1000", disp4); end
  endtask

  task automatic test_lock();
    do_reset();
    pulse2(1'b1, 1'b0);
    step(7197);
    checks++; if ({disp2, run2, max2} !== {16'h5958, 2'b10}) begin errors++; $display("FAIL lock_pre got %h want 16562", {disp2, run2, max2}); end
    step(1);
    checks++; if ({disp2, run2, max2} !== {16'h5959, 2'b01}) begin errors++; $display("FAIL lock_enter got %h want 16565", {disp2, run2, max2}); end
    step(10);
    pulse2(1'b1, 1'b0);
    checks++; if ({disp2, run2, max2} !== {16'h5959, 2'b01}) begin errors++; $display("FAIL lock_ss_ignored got %h want 16565", {disp2, run2, max2}); end
    pulse2(1'b0, 1'b1);
    checks++; if ({disp2, run2, max2} !== 18'h0) begin errors++; $display("FAIL lock_clear got %h want 0", {disp2, run2, max2}); end
    pulse2(1'b1, 1'b0);
    step(7194);
    pulse2(1'b0, 1'b1);
    checks++; if ({lap2, disp2} !== {1'b1, 16'h5957}) begin errors++; $display("FAIL lap_near_max got %h want 15957", {lap2, disp2}); end
    step(2);
    checks++; if ({lap2, max2, disp2} !== {2'b10, 16'h5957}) begin errors++; $display("FAIL lap_frozen_max got %h want 25957", {lap2, max2, disp2}); end
    step(1);
    checks++; if ({lap2, max2, disp2} !== {2'b01, 16'h5959}) begin errors++; $display("FAIL lap_to_lock got %h want 15959", {lap2, max2, disp2}); end
    pulse2(1'b0, 1'b1);
  endtask

  task automatic test_both();
    do_reset();
    pulse4(1'b1, 1'b0);
    step(4);
    pulse4(1'b1, 1'b1);
    checks++; if ({run4, lap4, disp4} !== {2'b00, 16'h0001}) begin errors++; $display("FAIL both_run got %h want 00001", {run4, lap4, disp4}); end
    pulse4(1'b1, 1'b1);
    checks++; if ({run4, lap4} !== 2'b10) begin errors++; $display("FAIL both_pause got %b want 10", {run4, lap4}); end
    step(3);
    checks++; if (disp4 !== 16'h0002) begin errors++; $display("FAIL both_resume_count got %h want 0002", disp4); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse4(1'b1, 1'b0);
    step(6);
    rst_n = 1'b0;
    #1;
    checks++; if ({disp4, run4, lap4, max4} !== 19'h0) begin errors++; $display("FAIL async_reset got %h want 0", {disp4, run4, lap4, max4}); end
    rst_n = 1'b1;
    step(2);
    checks++; if ({disp4, run4} !== 17'h0) begin errors++; $display("FAIL post_reset_idle got %h want 0", {disp4, run4}); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ss4 = 1'b0; lr4 = 1'b0; ss2 = 1'b0; lr2 = 1'b0;
    test_reset();
    test_run();
    test_lap();
    test_pause();
    test_tick_on_pause();
    test_wrap();
    test_lock();
    test_both();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
